// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with frame-synchronous double-buffered data.
// Define SEG7_LZ_BLANK_EN to switch off anodes of leading-zero digits (digit 0 always shown).
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] data_i,
  input  logic        load_i,
  input  logic [7:0]  dp_i,
  input  logic        blank_i,
  output logic [7:0]  disp_seg_o,
  output logic [7:0]  disp_an_o,
  output logic        frame_o
);

  localparam int unsigned   DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
  } disp_t;

  logic [DW-1:0] div_q;
  logic [2:0]    idx_q;
  logic          tick;
  logic          frame_bnd;
  disp_t         shown_q;
  disp_t         pend_q;
  logic          pend_v_q;
  logic [3:0]    nib;
  logic [7:0]    font;
  logic [7:0]    an_d;
  logic [7:0]    seg_d;

  function automatic logic [7:0] hexfont(input logic [3:0] n);
    logic [7:0] f;
    case (n)
      4'h0: f = 8'hC0;  4'h1: f = 8'hF9;  4'h2: f = 8'hA4;  4'h3: f = 8'hB0;
      4'h4: f = 8'h99;  4'h5: f = 8'h92;  4'h6: f = 8'h82;  4'h7: f = 8'hF8;
      4'h8: f = 8'h80;  4'h9: f = 8'h90;  4'hA: f = 8'h88;  4'hB: f = 8'h83;
      4'hC: f = 8'hC6;  4'hD: f = 8'hA1;  4'hE: f = 8'h86;  default: f = 8'h8E;
    endcase
    return f;
  endfunction

  assign tick      = (div_q == DIV_LAST);
  assign frame_bnd = tick && (idx_q == 3'd7);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (tick) begin
      div_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Displayed data changes only on the 7->0 wrap, so a frame never mixes old and new digits.
  // NOTE: the pending copy is reset along with its valid flag; a load lost to reset must never resurface.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shown_q  <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else if (frame_bnd) begin
      pend_v_q <= 1'b0;
      if (load_i)        shown_q <= {data_i, dp_i};
      else if (pend_v_q) shown_q <= pend_q;
    end else if (load_i) begin
      pend_q   <= {data_i, dp_i};
      pend_v_q <= 1'b1;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [7:0] lz_off;
  logic       upper_zero;

  // Walk from the top digit down: a digit is dark while it and everything above it is zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_off     = '0;
    for (int k = 7; k >= 1; k--) begin
      upper_zero = upper_zero & (shown_q.data[4*k +: 4] == 4'h0);
      lz_off[k]  = upper_zero & ~shown_q.dp[k];
    end
  end
`endif

  // NOTE: every combinational output is given a default first so no latch is inferred.
  always_comb begin
    nib   = shown_q.data[{idx_q, 2'b00} +: 4];
    font  = hexfont(nib);
    seg_d = {~shown_q.dp[idx_q], font[6:0]};
    an_d  = ~(8'd1 << idx_q);
`ifdef SEG7_LZ_BLANK_EN
    if (lz_off[idx_q]) an_d = 8'hFF;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_an_o  <= 8'hFF;
      disp_seg_o <= 8'hFF;
      frame_o    <= 1'b0;
    end else begin
      frame_o <= frame_bnd;
      if (blank_i) begin
        disp_an_o  <= 8'hFF;
        disp_seg_o <= 8'hFF;
      end else begin
        disp_an_o  <= an_d;
        disp_seg_o <= seg_d;
      end
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles each digit is held; legal range >= 2.
REQ-002 SHALL have port clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset; one clock; asynchronous, active-low.
REQ-004 SHALL have port data_i  input  32  eight hex nibbles to display; nibble k = data_i[4k+3:4k] maps to digit k.
REQ-005 SHALL have port load_i  input  1  one-cycle strobe capturing data_i and dp_i into the pending register.
REQ-006 SHALL have port dp_i  input  8  decimal-point enables; bit k lights the DP of digit k.
REQ-007 SHALL have port blank_i  input  1  level; forces all anodes and segments off while high.
REQ-008 SHALL have port disp_seg_o  output  8  active-low segments; bit7=dp, bits6:0=g,f,e,d,c,b,a.
REQ-009 SHALL have port disp_an_o  output  8  active-low anodes; bit k selects digit k.
REQ-010 SHALL have port frame_o  output  1  one-cycle pulse when the digit index wraps from 7 to 0.

Function
REQ-011 SHALL run a divider counter 0..SCAN_DIV-1; the terminal-count cycle is the "tick".
REQ-012 SHALL advance the 3-bit digit index on each tick, wrapping 7 -> 0.
REQ-013 SHALL define a "frame boundary" as a tick with index 7, and assert frame_o during the cycle after it.
REQ-014 SHALL keep a displayed register (32-bit data + 8-bit dp) and a pending register with a valid flag.
REQ-015 SHALL update the displayed register only at a frame boundary, so no frame shows mixed old and new data.
REQ-016 SHALL capture data_i/dp_i into pending when load_i is high outside a frame boundary; a later load overwrites an uncommitted one (latest wins).
REQ-017 SHALL, when load_i coincides with a frame boundary, commit data_i/dp_i directly to the displayed register and clear the pending valid flag.
REQ-018 SHALL, at a frame boundary without load_i, commit pending if valid and clear valid; otherwise leave the displayed register unchanged.
REQ-019 SHALL register disp_an_o/disp_seg_o every cycle from the current index and displayed register: one output cycle of latency.
REQ-020 SHALL drive disp_an_o = ~(1 << index) and disp_seg_o = {~dp[index], hexfont(nibble[index])}.
REQ-021 SHALL use hexfont active-low values, DP off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-022 SHALL, while blank_i is high, drive both outputs 8'hFF on the next cycle; the divider, index and load logic keep running.

Reset
REQ-023 SHALL, on rstn low, immediately clear the divider, index, displayed register, dp and pending valid flag, and set frame_o=0 and disp_an_o=disp_seg_o=8'hFF.
REQ-024 SHALL, after rstn rises, drive disp_an_o=8'hFE and disp_seg_o=8'hC0 from the first rising edge.
REQ-025 SHALL discard any uncommitted pending load when reset is asserted mid-frame.

Configuration
REQ-026 SHALL, with SEG7_LZ_BLANK_EN defined, blank leading zeros: digit k (k>0) has its anode off when nibbles k..7 of the displayed data are all zero and dp[k]=0; digit 0 is never blanked.
REQ-027 SHALL, without SEG7_LZ_BLANK_EN, scan all eight digits unconditionally.

Verification (SCAN_DIV=4)
REQ-028 SHALL cover reset release: disp_an_o sequence FE, FD, FB, ... 7F, FE with each value held 4 cycles; frame_o pulses every 32 cycles.
REQ-029 SHALL cover a mid-frame load of 0x1234ABCD: display shows 0 until the next frame boundary, then digit0=A1(d), digit4=99(4), digit7=F9(1).
REQ-030 SHALL cover two loads (0x11111111, then 0x22222222) in the same frame: only 0x22222222 is displayed, and never a mix.
REQ-031 SHALL cover load_i in the frame-boundary cycle: the new data appears at digit 0 of the very next frame.
REQ-032 SHALL cover blank_i high for 10 cycles: outputs read FF for those cycles, and frame_o timing is unchanged.
REQ-033 SHALL cover, with SEG7_LZ_BLANK_EN defined, data 0x00000050 and dp=0: anodes for digits 2..7 stay off, while digits 0 and 1 show C0 and 92.
